bus_ctrl_sequencer: RTL

Control-side transaction sequencer for the shared 8-bit crypto interconnect. It accepts a transfer request (source, destination, opcode, length) from the controller FSM and drives the header packet through the controller's own bus port (ID 2'b11). It then holds off for the ownership hand-over gap, counts the data beats the source module places on the bus, and asserts `ack` on the last beat to close the transaction. It is the initiator/terminator counterpart to every module's bus port.

---
 rtl/bus_pkg.sv | 42 ++++
 rtl/bus_seq_timer.sv | 38 +++
 rtl/bus_ctrl_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the 8-bit crypto interconnect: module IDs, header layout,
// opcodes and the sequencer state encoding.
package bus_pkg;

  localparam logic [1:0] CTRL_ID = 2'b11;

  localparam int HDR_OP_MSB  = 7;
  localparam int HDR_OP_LSB  = 6;
  localparam int HDR_SRC_MSB = 5;
  localparam int HDR_SRC_LSB = 4;
  localparam int HDR_DST_MSB = 3;
  localparam int HDR_DST_LSB = 2;

  localparam int GAP_CYCLES_DEF = 3;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2,
    OP_EXEC  = 2'd3
  } bus_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_GAP,
    ST_XFER,
    ST_ACK
  } seq_state_e;

  function automatic logic [7:0] make_header(input logic [1:0] op,
                                             input logic [1:0] src,
                                             input logic [1:0] dst);
    logic [7:0] h;
    h = '0;
    h[HDR_OP_MSB:HDR_OP_LSB]   = op;
    h[HDR_SRC_MSB:HDR_SRC_LSB] = src;
    h[HDR_DST_MSB:HDR_DST_LSB] = dst;
    return h;
  endfunction

endpackage

// File: rtl/bus_seq_timer.sv
// Idle-beat watchdog for the sequencer XFER phase: reloads on load, counts while
// enabled, flags expiry in the cycle the count reaches LIMIT-1 without a reload.
module bus_seq_timer #(
  parameter int WIDTH = 11,
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (en && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = en && !load && (count_q == LAST);

endmodule

// File: rtl/bus_ctrl_sequencer.sv
// Controller-side transaction sequencer: header, ownership gap, beat counting, ack.
// Optional XFER watchdog enabled by defining BUS_SEQ_TIMEOUT_EN.
module bus_ctrl_sequencer
  import bus_pkg::*;
#(
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
`ifdef BUS_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [1:0] req_src,
  input  logic [1:0] req_dst,
  input  logic [7:0] req_len,
  output logic       ctrl_send_valid,
  output logic [7:0] ctrl_send_data,
  input  logic       bus_valid_mon,
  output logic       ack,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] beat_cnt
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  seq_state_e       state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       beat_cnt_q, beat_cnt_d;
  logic             req_ready_q, req_ready_d;
  logic             send_valid_q, send_valid_d;
  logic [7:0]       send_data_q, send_data_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ack_last;
  logic             timeout_fire;
  logic             timer_expired;

`ifdef BUS_SEQ_TIMEOUT_EN
  logic timer_load;
  logic timer_en;

  // Held cleared outside XFER so every XFER entry starts a fresh window.
  assign timer_en   = (state_q == ST_XFER);
  assign timer_load = (state_q != ST_XFER) || bus_valid_mon;

  bus_seq_timer #(
    .WIDTH($clog2(TIMEOUT_CYCLES + 1)),
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .en     (timer_en),
    .expired(timer_expired)
  );
`else
  assign timer_expired = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    send_valid_d = 1'b0;
    send_data_d  = '0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    ack_last     = 1'b0;
    timeout_fire = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          len_d = req_len;
          if ((req_len == 8'd0) || (req_src == CTRL_ID) || (req_src == req_dst)) begin
            err_d = 1'b1;
          end else begin
            state_d      = ST_HDR;
            beat_cnt_d   = '0;
            send_valid_d = 1'b1;
            send_data_d  = make_header(req_op, req_src, req_dst);
          end
        end
      end
      ST_HDR: begin
        state_d   = ST_GAP;
        gap_cnt_d = '0;
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_XFER;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      ST_XFER: begin
        if (bus_valid_mon) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if ((beat_cnt_q + 8'd1) == len_q) begin
            ack_last = 1'b1;
            done_d   = 1'b1;
            state_d  = ST_ACK;
          end
        end else if (timer_expired) begin
          timeout_fire = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gap_cnt_q    <= '0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      req_ready_q  <= 1'b0;
      send_valid_q <= 1'b0;
      send_data_q  <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
      req_ready_q  <= req_ready_d;
      send_valid_q <= send_valid_d;
      send_data_q  <= send_data_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Last-beat ack rides on the beat itself; a timeout also raises ack to release the bus.
  assign ack             = ack_last | timeout_fire;
  assign err             = err_q | timeout_fire;
  assign req_ready       = req_ready_q;
  assign ctrl_send_valid = send_valid_q;
  assign ctrl_send_data  = send_data_q;
  assign done            = done_q;
  assign busy            = (state_q != ST_IDLE);
  assign beat_cnt        = beat_cnt_q;

endmodule
